// File: rtl/dds_sweep_ctrl_if.sv
// Sweep control bundle between the key/UART front end and the DDS sweep sequencer.
// Master is the control side; slave is dds_sweep_ctrl.
interface dds_sweep_ctrl_if #(
  parameter int FW      = 32,
  parameter int PW      = 12,
  parameter int DWELL_W = 16
);
  logic               Start;
  logic               Stop;
  logic [FW-1:0]      F_start;
  logic [FW-1:0]      F_stop;
  logic [FW-1:0]      F_step;
  logic [DWELL_W-1:0] Dwell;
  logic [PW-1:0]      Pword_in;
  logic [1:0]         Wave_sel_in;
  logic [FW-1:0]      Fword;
  logic [PW-1:0]      Pword;
  logic [1:0]         Module_Sel;
  logic               Busy;
  logic               Sweep_done;

  modport master (
    output Start, Stop, F_start, F_stop, F_step, Dwell,
    output Pword_in, Wave_sel_in,
    input  Fword, Pword, Module_Sel, Busy, Sweep_done
  );

  modport slave (
    input  Start, Stop, F_start, F_stop, F_step, Dwell,
    input  Pword_in, Wave_sel_in,
    output Fword, Pword, Module_Sel, Busy, Sweep_done
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Stepped linear frequency sweep sequencer driving the DDS Fword/Pword/Module_Sel.
// Define DDS_SWEEP_BIDIR_EN to add the down-leg (DOWN state) after the up-leg.
module dds_sweep_ctrl #(
  parameter int FW      = 32,
  parameter int PW      = 12,
  parameter int DWELL_W = 16
) (
  input  logic           Clk,
  input  logic           Reset_n,
  dds_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state;

  logic [FW-1:0]      r_fword;
  logic [PW-1:0]      r_pword;
  logic [1:0]         r_msel;
  logic               r_busy;
  logic               r_done;
  logic [DWELL_W-1:0] r_cnt;
  logic [FW-1:0]      r_fstop;
  logic [FW-1:0]      r_fstep;
  logic [DWELL_W-1:0] r_dwell;

  logic [FW-1:0]      w_fword;
  logic [PW-1:0]      w_pword;
  logic [1:0]         w_msel;
  logic               w_busy;
  logic               w_done;
  logic [DWELL_W-1:0] w_cnt;
  logic [FW-1:0]      w_fstop;
  logic [FW-1:0]      w_fstep;
  logic [DWELL_W-1:0] w_dwell;

  logic [FW-1:0]      w_step_in;
  logic [FW-1:0]      w_up_gap;
  logic               w_cnt_zero;
  logic               w_go;

`ifdef DDS_SWEEP_BIDIR_EN
  logic [FW-1:0]      r_fstart;
  logic [FW-1:0]      w_fstart;
  logic [FW-1:0]      w_dn_gap;

  assign w_dn_gap = r_fword - r_fstart;
`endif

  // A zero step would stall the sweep forever, so it is promoted to 1.
  assign w_step_in  = (bus.F_step == '0) ?
                      {{(FW-1){1'b0}}, 1'b1} : bus.F_step;
  assign w_up_gap   = r_fstop - r_fword;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_go       = bus.Start & ~bus.Stop;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_fword  <= '0;
      r_pword  <= '0;
      r_msel   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_fstop  <= '0;
      r_fstep  <= '0;
      r_dwell  <= '0;
`ifdef DDS_SWEEP_BIDIR_EN
      r_fstart <= '0;
`endif
    end else begin
      r_state  <= w_state;
      r_fword  <= w_fword;
      r_pword  <= w_pword;
      r_msel   <= w_msel;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_cnt    <= w_cnt;
      r_fstop  <= w_fstop;
      r_fstep  <= w_fstep;
      r_dwell  <= w_dwell;
`ifdef DDS_SWEEP_BIDIR_EN
      r_fstart <= w_fstart;
`endif
    end
  end

  always_comb begin
    w_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) w_state = S_UP;
      end
      S_UP: begin
        if (bus.Stop) begin
          w_state = S_IDLE;
        end else if (w_cnt_zero && (r_fword >= r_fstop)) begin
`ifdef DDS_SWEEP_BIDIR_EN
          w_state = S_DOWN;
`else
          w_state = S_IDLE;
`endif
        end
      end
`ifdef DDS_SWEEP_BIDIR_EN
      S_DOWN: begin
        if (bus.Stop) begin
          w_state = S_IDLE;
        end else if (w_cnt_zero && (r_fword <= r_fstart)) begin
          w_state = S_IDLE;
        end
      end
`endif
      default: w_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_fword  = r_fword;
    w_pword  = r_pword;
    w_msel   = r_msel;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_cnt    = r_cnt;
    w_fstop  = r_fstop;
    w_fstep  = r_fstep;
    w_dwell  = r_dwell;
`ifdef DDS_SWEEP_BIDIR_EN
    w_fstart = r_fstart;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_pword = bus.Pword_in;
        w_msel  = bus.Wave_sel_in;
        w_busy  = 1'b0;
        if (w_go) begin
          w_fstop  = bus.F_stop;
          w_fstep  = w_step_in;
          w_dwell  = bus.Dwell;
`ifdef DDS_SWEEP_BIDIR_EN
          w_fstart = bus.F_start;
`endif
          w_fword  = bus.F_start;
          w_cnt    = bus.Dwell;
          w_busy   = 1'b1;
        end
      end
      S_UP: begin
        if (bus.Stop) begin
          w_busy = 1'b0;
        end else if (!w_cnt_zero) begin
          w_cnt = r_cnt - 1'b1;
        end else if (r_fword >= r_fstop) begin
`ifdef DDS_SWEEP_BIDIR_EN
          w_cnt  = r_dwell;
`else
          w_busy = 1'b0;
          w_done = 1'b1;
`endif
        end else if (w_up_gap <= r_fstep) begin
          w_fword = r_fstop;
          w_cnt   = r_dwell;
        end else begin
          w_fword = r_fword + r_fstep;
          w_cnt   = r_dwell;
        end
      end
`ifdef DDS_SWEEP_BIDIR_EN
      // Mirror of the up-leg, clamping onto the latched start frequency.
      S_DOWN: begin
        if (bus.Stop) begin
          w_busy = 1'b0;
        end else if (!w_cnt_zero) begin
          w_cnt = r_cnt - 1'b1;
        end else if (r_fword <= r_fstart) begin
          w_busy = 1'b0;
          w_done = 1'b1;
        end else if (w_dn_gap <= r_fstep) begin
          w_fword = r_fstart;
          w_cnt   = r_dwell;
        end else begin
          w_fword = r_fword - r_fstep;
          w_cnt   = r_dwell;
        end
      end
`endif
      default: w_busy = 1'b0;
    endcase
  end

  assign bus.Fword      = r_fword;
  assign bus.Pword      = r_pword;
  assign bus.Module_Sel = r_msel;
  assign bus.Busy       = r_busy;
  assign bus.Sweep_done = r_done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed scoreboard bench for dds_sweep_ctrl.
// Expected per-cycle outputs are queued before stimulus and popped after each edge.
module tb_dds_sweep_ctrl;

  logic Clk;
  logic Reset_n;

  dds_sweep_ctrl_if #(.FW(32), .PW(12), .DWELL_W(16)) bus ();

  dds_sweep_ctrl #(.FW(32), .PW(12), .DWELL_W(16)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] f;
    logic [11:0] p;
    logic [1:0]  m;
    logic        b;
    logic        d;
  } obs_t;

  obs_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t sample();
    obs_t o;
    o = {bus.Fword, bus.Pword, bus.Module_Sel, bus.Busy, bus.Sweep_done};
    return o;
  endfunction

  task automatic push(input logic [31:0] f, input logic [11:0] p,
                      input logic [1:0] m, input logic b, input logic d,
                      input int n);
    obs_t e;
    e = {f, p, m, b, d};
    for (int i = 0; i < n; i++) sbq.push_back(e);
  endtask

  task automatic compare(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got f=%0d p=%h m=%0d b=%b d=%b want f=%0d p=%h m=%0d b=%b d=%b",
             tag, got.f, got.p, got.m, got.b, got.d,
             exp.f, exp.p, exp.m, exp.b, exp.d);
    end
  endtask

  task automatic check_one(input string tag);
    obs_t exp;
    @(posedge Clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty got f=%0d want queued entry",
             tag, bus.Fword);
    end else begin
      exp = sbq.pop_front();
      compare(tag, sample(), exp);
    end
  endtask

  task automatic drain(input string tag);
    while (sbq.size() > 0) check_one(tag);
  endtask

  task automatic kick(input string tag, input logic [31:0] fs,
                      input logic [31:0] fe, input logic [31:0] st,
                      input logic [15:0] dw);
    @(negedge Clk);
    bus.F_start = fs;
    bus.F_stop  = fe;
    bus.F_step  = st;
    bus.Dwell   = dw;
    bus.Start   = 1'b1;
    check_one(tag);
    bus.Start   = 1'b0;
  endtask

  initial begin
    bus.Start       = 1'b0;
    bus.Stop        = 1'b0;
    bus.F_start     = '0;
    bus.F_stop      = '0;
    bus.F_step      = '0;
    bus.Dwell       = '0;
    bus.Pword_in    = 12'h123;
    bus.Wave_sel_in = 2'd2;
    Reset_n         = 1'b0;

    repeat (3) @(posedge Clk);
    #1;
    compare("reset", sample(), '0);
    @(negedge Clk);
    Reset_n = 1'b1;
    push(0, 12'h123, 2'd2, 1'b0, 1'b0, 2);
    drain("idle_track");

`ifndef DDS_SWEEP_BIDIR_EN
    // Basic sweep, each frequency held Dwell+1 = 3 cycles.
    push(1000, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1100, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1200, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1300, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1300, 12'h123, 2'd2, 1'b0, 1'b1, 1);
    push(1300, 12'h123, 2'd2, 1'b0, 1'b0, 2);
    kick("t1_sweep", 1000, 1300, 100, 2);
    drain("t1_sweep");

    // Last step clamps onto F_stop.
    push(1000, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(1250, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(1300, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(1300, 12'h123, 2'd2, 1'b0, 1'b1, 1);
    push(1300, 12'h123, 2'd2, 1'b0, 1'b0, 1);
    kick("t2_clamp", 1000, 1300, 250, 0);
    drain("t2_clamp");

    // Abort while Fword=1100.
    push(1000, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1100, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    kick("t3_pre", 1000, 1300, 100, 2);
    drain("t3_pre");
    @(negedge Clk);
    bus.Stop = 1'b1;
    push(1100, 12'h123, 2'd2, 1'b0, 1'b0, 1);
    check_one("t3_stop");
    bus.Stop = 1'b0;
    push(1100, 12'h123, 2'd2, 1'b0, 1'b0, 4);
    drain("t3_no_done");

    // Start and Stop together in IDLE: no sweep.
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Stop  = 1'b1;
    push(1100, 12'h123, 2'd2, 1'b0, 1'b0, 1);
    check_one("t3_start_stop");
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
    push(1100, 12'h123, 2'd2, 1'b0, 1'b0, 2);
    drain("t3_start_stop");

    // Zero step treated as 1.
    push(5, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(6, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(7, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(8, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(8, 12'h123, 2'd2, 1'b0, 1'b1, 1);
    push(8, 12'h123, 2'd2, 1'b0, 1'b0, 1);
    kick("t4_step0", 5, 8, 0, 0);
    drain("t4_step0");

    // F_start above F_stop: one dwell, no step.
    push(9, 12'h123, 2'd2, 1'b1, 1'b0, 2);
    push(9, 12'h123, 2'd2, 1'b0, 1'b1, 1);
    push(9, 12'h123, 2'd2, 1'b0, 1'b0, 1);
    kick("t4_inverted", 9, 8, 1, 1);
    drain("t4_inverted");

    // Start and config changes while Busy are ignored.
    push(1000, 12'h123, 2'd2, 1'b1, 1'b0, 2);
    push(1100, 12'h123, 2'd2, 1'b1, 1'b0, 2);
    push(1200, 12'h123, 2'd2, 1'b1, 1'b0, 2);
    push(1200, 12'h123, 2'd2, 1'b0, 1'b1, 1);
    push(1200, 12'h7ff, 2'd1, 1'b0, 1'b0, 2);
    kick("t5_busy", 1000, 1200, 100, 1);
    check_one("t5_busy");
    @(negedge Clk);
    bus.Start       = 1'b1;
    bus.Pword_in    = 12'h7ff;
    bus.Wave_sel_in = 2'd1;
    bus.F_stop      = 5000;
    bus.F_start     = 3;
    check_one("t5_restart");
    bus.Start = 1'b0;
    drain("t5_busy");
`else
    // Up then down leg; F_stop held for two dwells.
    push(1000, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1100, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1200, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1300, 12'h123, 2'd2, 1'b1, 1'b0, 6);
    push(1200, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1100, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1000, 12'h123, 2'd2, 1'b1, 1'b0, 3);
    push(1000, 12'h123, 2'd2, 1'b0, 1'b1, 1);
    push(1000, 12'h123, 2'd2, 1'b0, 1'b0, 2);
    kick("t6_bidir", 1000, 1300, 100, 2);
    drain("t6_bidir");

    push(1000, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(1250, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(1300, 12'h123, 2'd2, 1'b1, 1'b0, 2);
    push(1050, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(1000, 12'h123, 2'd2, 1'b1, 1'b0, 1);
    push(1000, 12'h123, 2'd2, 1'b0, 1'b1, 1);
    kick("t6_clamp", 1000, 1300, 250, 0);
    drain("t6_clamp");
`endif

    // Asynchronous reset in the middle of a sweep.
    bus.Pword_in    = 12'h0a5;
    bus.Wave_sel_in = 2'd3;
    push(2000, 12'h0a5, 2'd3, 1'b1, 1'b0, 3);
    kick("t5_rst_pre", 2000, 3000, 10, 4);
    drain("t5_rst_pre");
    #3;
    Reset_n = 1'b0;
    #1;
    compare("t5_async_rst", sample(), '0);
    @(negedge Clk);
    Reset_n = 1'b1;
    push(0, 12'h0a5, 2'd3, 1'b0, 1'b0, 2);
    drain("t5_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
